stream_fifo: RTL and testbench



---
 rtl/stream_fifo_pkg.sv | 19 +
 rtl/stream_fifo_mem.sv | 35 +++
 rtl/stream_fifo.sv | 95 +++++++++
 tb/tb_stream_fifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared helpers for the stream_fifo block: pointer sizing and parameter checks.
package stream_fifo_pkg;

  // Pointer width for a given number of entries.
  function automatic int ptr_w(int depth);
    return $clog2(depth);
  endfunction

  // DEPTH must be a power of two and at least 2 so pointers wrap naturally.
  function automatic bit depth_ok(int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // AFULL_LVL must lie within 1..DEPTH.
  function automatic bit afull_ok(int lvl, int depth);
    return (lvl >= 1) && (lvl <= depth);
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH register array: one write port, one asynchronous read port, no reset.
module stream_fifo_mem
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] wsel;

  // One-hot write select, one decoder bit per entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
    assign wsel[gi] = we && (waddr == PW'(gi));
  end

  // Capture write data into the selected entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wsel[i]) mem_reg[i] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO with first-word fall-through output, fill level
// and almost-full flag. Feeds the downstream pass-through stage from out_data.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter int               AFULL_LVL = 3,
  parameter logic [WIDTH-1:0] CLR_VAL   = '0,
  parameter bit               USE_CLR   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        afull
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  // Illegal configurations stop elaboration rather than building a broken FIFO.
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and at least 2");
  end
  if (!afull_ok(AFULL_LVL, DEPTH)) begin : g_bad_afull
    $error("stream_fifo: AFULL_LVL must be within 1..DEPTH");
  end

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             push, pop, clr_eff;
  logic [WIDTH-1:0] head_data;

  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign level     = count_reg;
  assign afull     = (count_reg >= CW'(AFULL_LVL));
  // Empty FIFO shows the idle value instead of stale storage.
  assign out_data  = out_valid ? head_data : CLR_VAL;

  assign push    = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign clr_eff = USE_CLR && clr;

  // Next-state for pointers and count; a flush overrides any handshake.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clr_eff) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
      if (push && !pop)      count_next = count_reg + CW'(1);
      else if (pop && !push) count_next = count_reg - CW'(1);
    end
  end

  // Pointer and count registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  stream_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !clr_eff),
    .waddr (wr_ptr_reg),
    .wdata (in_data),
    .raddr (rd_ptr_reg),
    .rdata (head_data)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: the driver queues expected words as it
// issues them, a negedge monitor pops and compares on every output handshake.
module tb_stream_fifo;

  localparam logic [7:0] CLR = 8'hC5;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, afull;
  logic [7:0] out_data;
  logic [2:0] level;
  logic       nc_in_ready, nc_out_valid, nc_afull;
  logic [7:0] nc_out_data;
  logic [2:0] nc_level;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expq[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  stream_fifo #(
    .WIDTH(8), .DEPTH(4), .AFULL_LVL(3), .CLR_VAL(CLR), .USE_CLR(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .afull(afull)
  );

  // Same stimulus, flush disabled.
  stream_fifo #(
    .WIDTH(8), .DEPTH(4), .AFULL_LVL(3), .CLR_VAL(CLR), .USE_CLR(1'b0)
  ) dut_nc (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(nc_in_ready), .in_data(in_data),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data),
    .level(nc_level), .afull(nc_afull)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d, input bit expect_accept);
    in_valid = 1'b1;
    in_data  = d;
    if (expect_accept) expq.push_back(d);
  endtask

  // Monitor: every output handshake must deliver the oldest queued word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", out_data);
      end else begin
        mon_exp = expq.pop_front();
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL pop_data actual=%0h required=%0h", out_data, mon_exp);
        end else begin
          $display("pop  data=%0h", out_data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_afull", afull, 0);
    chk("rst_out_data", out_data, CLR);
    rst_n = 1'b1;

    // Fill: 0x11..0x44 accepted, 0x55 refused while full.
    for (int i = 0; i < 5; i++) begin
      push_word(8'((i + 1) * 8'h11), i < 4);
      step();
      chk("fill_level", level, (i < 4) ? i + 1 : 4);
      chk("fill_afull", afull, (i >= 2) ? 1 : 0);
      chk("fill_in_ready", in_ready, (i < 3) ? 1 : 0);
    end
    in_valid = 1'b0;

    // Drain from full.
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_out_data", out_data, CLR);
    chk("drain_level", level, 0);
    out_ready = 1'b0;

    // Streaming at level 2, data 0..19, pointers wrap repeatedly.
    push_word(8'd0, 1'b1); step();
    push_word(8'd1, 1'b1); step();
    out_ready = 1'b1;
    for (int d = 2; d < 20; d++) begin
      push_word(8'(d), 1'b1);
      step();
      chk("stream_level", level, 2);
    end
    in_valid = 1'b0;
    step();
    step();
    chk("stream_end_level", level, 0);

    // No fall-through: 0xAA into empty FIFO with consumer ready.
    push_word(8'hAA, 1'b1);
    #2;
    chk("aa_valid_before", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("aa_valid_after", out_valid, 1);
    chk("aa_data_after", out_data, 8'hAA);
    step();
    chk("aa_popped", out_valid, 0);
    out_ready = 1'b0;

    // Flush at level 3 with a concurrent push.
    for (int i = 0; i < 3; i++) begin
      push_word(8'(8'h31 + i), 1'b1);
      step();
    end
    chk("preclr_level", level, 3);
    chk("preclr_afull", afull, 1);
    clr = 1'b1;
    push_word(8'h34, 1'b0);
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    chk("clr_level", level, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("noclr_level", nc_level, 4);
    chk("noclr_afull", nc_afull, 1);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      push_word(8'(8'h61 + i), 1'b1);
      step();
    end
    in_valid = 1'b0;
    chk("prerst_level", level, 3);
    #2;
    rst_n = 1'b0;
    expq.delete();
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_afull", afull, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_nc_level", nc_level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_word(8'h77, 1'b1);
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 8'h77);
    out_ready = 1'b1;
    step();
    chk("post_rst_empty", out_valid, 0);
    out_ready = 1'b0;

    chk("scoreboard_left", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
